// File: rtl/alu_nibble_seq.sv
// Runs 4*NIBBLES-bit 74181 operations through one external 4-bit slice, LSB nibble first.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the registered out_zero result flag.
module alu_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_s,
    input  logic                 in_m,
    input  logic                 in_ci,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_y,
    output logic                 out_co,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic                 out_zero,
`endif
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_ci,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [3:0]           alu_y,
    input  logic                 alu_co
);

    localparam int unsigned WIDTH = 4 * NIBBLES;
    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               co_q, co_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic               zero_q, zero_d;
`endif

    // Operand registers shift right one nibble per RUN edge, so the low nibble
    // always feeds the slice and they drain to zero once the operation ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            m_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            co_q    <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            co_q    <= co_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        co_d    = co_q;
        valid_d = valid_q;
        ready_d = ready_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    s_d     = in_s;
                    m_d     = in_m;
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_ci;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                y_d[{cnt_q, 2'b00} +: 4] = alu_y;
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = alu_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_NIB) begin
                    // Carry leaves the chain as out_co; the slice carry input returns to 0.
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    co_d    = alu_co;
                    valid_d = 1'b1;
                    state_d = DONE;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    zero_d  = (y_d == '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_y     = y_q;
    assign out_co    = co_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign out_zero  = zero_q;
`endif
    assign alu_s     = s_q;
    assign alu_m     = m_q;
    assign alu_ci    = carry_q;
    assign alu_a     = a_q[3:0];
    assign alu_b     = b_q[3:0];

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: word-level 74181 reference model plus directed vectors.
module tb_alu_nibble_seq;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_s;
    logic          in_m;
    logic          in_ci;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          out_co;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic          out_zero;
`endif
    logic [3:0]    alu_s;
    logic          alu_m;
    logic          alu_ci;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [3:0]    alu_y;
    logic          alu_co;

    alu_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_m      (in_m),
        .in_ci     (in_ci),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_co    (out_co),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .alu_s     (alu_s),
        .alu_m     (alu_m),
        .alu_ci    (alu_ci),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_co    (alu_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level 74181 (active-high data, Cn/Cn+4 active-low carries) at any width up to 64.
    // Returns {cn4, result}.
    function automatic logic [64:0] f181(input logic [3:0] s, input logic m, input logic ci,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input int w);
        logic [63:0] mask, nb, x, y, lg;
        logic [64:0] sum;
        mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        nb   = ~b;
        case (s)
            4'h0: begin x = a;      y = 64'd0;  lg = ~a;       end
            4'h1: begin x = a | b;  y = 64'd0;  lg = ~(a | b); end
            4'h2: begin x = a | nb; y = 64'd0;  lg = ~a & b;   end
            4'h3: begin x = 64'd0;  y = mask;   lg = 64'd0;    end
            4'h4: begin x = a;      y = a & nb; lg = ~(a & b); end
            4'h5: begin x = a | b;  y = a & nb; lg = nb;       end
            4'h6: begin x = a;      y = nb;     lg = a ^ b;    end
            4'h7: begin x = a & nb; y = mask;   lg = a & nb;   end
            4'h8: begin x = a;      y = a & b;  lg = ~a | b;   end
            4'h9: begin x = a;      y = b;      lg = ~(a ^ b); end
            4'hA: begin x = a | nb; y = a & b;  lg = b;        end
            4'hB: begin x = a & b;  y = mask;   lg = a & b;    end
            4'hC: begin x = a;      y = a;      lg = mask;     end
            4'hD: begin x = a | b;  y = a;      lg = a | nb;   end
            4'hE: begin x = a | nb; y = a;      lg = a | b;    end
            default: begin x = a;   y = mask;   lg = a;        end
        endcase
        sum = {1'b0, x & mask} + {1'b0, y & mask} + 65'(!ci);
        return {~sum[w], (m ? lg : sum[63:0]) & mask};
    endfunction

    // Combinational slice driven by the DUT.
    logic [64:0] slice_r;
    always_comb begin
        slice_r = f181(alu_s, alu_m, alu_ci, 64'(alu_a), 64'(alu_b), 4);
        alu_y   = slice_r[3:0];
        alu_co  = slice_r[64];
    end

    // Transaction model: accept in idle, result valid NIB edges later, held until out_ready.
    int           m_cnt;
    logic         m_done;
    logic [3:0]   m_s;
    logic         m_m;
    logic         m_ci;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [64:0]  m_res;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_s    <= '0;
            m_m    <= 1'b0;
            m_ci   <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_res  <= '0;
        end else if (m_cnt == 0 && !m_done) begin
            if (in_valid) begin
                m_s   <= in_s;
                m_m   <= in_m;
                m_ci  <= in_ci;
                m_a   <= in_a;
                m_b   <= in_b;
                m_res <= f181(in_s, in_m, in_ci, 64'(in_a), 64'(in_b), W);
                m_cnt <= NIB;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [3:0] hist [0:19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int k;
        logic [64:0] low;
        chk("in_ready", 64'(in_ready), 64'(m_cnt == 0 && !m_done));
        chk("out_valid", 64'(out_valid), 64'(m_done));
        chk("alu_s", 64'(alu_s), 64'(m_s));
        chk("alu_m", 64'(alu_m), 64'(m_m));
        if (m_done) begin
            chk("out_y", 64'(out_y), 64'(m_res[W-1:0]));
            chk("out_co", 64'(out_co), 64'(m_res[64]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
            chk("out_zero", 64'(out_zero), 64'(m_res[W-1:0] == '0));
`endif
        end
        if (m_cnt > 0) begin
            k = NIB - m_cnt;
            chk("alu_a_run", 64'(alu_a), (64'(m_a) >> (4 * k)) & 64'hF);
            chk("alu_b_run", 64'(alu_b), (64'(m_b) >> (4 * k)) & 64'hF);
            low = f181(m_s, m_m, m_ci, 64'(m_a), 64'(m_b), 4 * k);
            chk("alu_ci_run", 64'(alu_ci), (k == 0) ? 64'(m_ci) : 64'(low[64]));
        end else begin
            chk("alu_a_idle", 64'(alu_a), 64'd0);
            chk("alu_b_idle", 64'(alu_b), 64'd0);
            chk("alu_ci_idle", 64'(alu_ci), 64'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
    endtask

    task automatic send(input logic [3:0] s, input logic m, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        in_s     = s;
        in_m     = m;
        in_ci    = ci;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_s     = ~s;
        in_ci    = ~ci;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        hist[0] = alu_a;
        while (!out_valid && n < 20) begin
            tick();
            n++;
            if (n < 20) hist[n] = alu_a;
        end
        chk("done_seen", 64'(out_valid), 64'd1);
    endtask

    int lat;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_s      = '0;
        in_m      = 1'b0;
        in_ci     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_out_co", 64'(out_co), 64'd0);
        reset_n = 1'b1;
        tick();

        // Add, no carry-in
        send(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001);
        wait_done(lat);
        chk("add_latency", 64'(lat), 64'd4);
        chk("add_y", 64'(out_y), 64'h0100);
        chk("add_co", 64'(out_co), 64'd1);
        tick();

        // Add with carry-in
        send(4'b1001, 1'b0, 1'b0, 16'h00FF, 16'h0001);
        wait_done(lat);
        chk("addc_y", 64'(out_y), 64'h0101);
        chk("addc_co", 64'(out_co), 64'd1);
        tick();

        // Full-width carry out
        send(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
        wait_done(lat);
        chk("wrap_y", 64'(out_y), 64'h0000);
        chk("wrap_co", 64'(out_co), 64'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("wrap_zero", 64'(out_zero), 64'd1);
`endif
        tick();

        // Logic XOR and nibble ordering on the slice bus
        send(4'b0110, 1'b1, 1'b1, 16'h1234, 16'hFFFF);
        wait_done(lat);
        chk("xor_y", 64'(out_y), 64'hEDCB);
        chk("xor_co", 64'(out_co), 64'd1);
        chk("xor_alu_a_seq", 64'({hist[0], hist[1], hist[2], hist[3]}), 64'h4321);
        tick();

        // Subtract with carry-in: 5 - 3
        send(4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0003);
        wait_done(lat);
        chk("sub_y", 64'(out_y), 64'h0002);
        chk("sub_co", 64'(out_co), 64'd0);
        tick();

        // Backpressure with ignored requests
        out_ready = 1'b0;
        send(4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h00F1);
        wait_done(lat);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 16'(i * 16'h1111);
            tick();
        end
        chk("bp_y", 64'(out_y), 64'h1000);
        chk("bp_co", 64'(out_co), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of RUN
        send(4'b1001, 1'b0, 1'b1, 16'h4321, 16'h1111);
        tick();
        tick();
        chk("mid_alu_a_k2", 64'(alu_a), 64'h3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_y", 64'(out_y), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_alu_a", 64'(alu_a), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        send(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h4321);
        wait_done(lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_y", 64'(out_y), 64'h5555);
        chk("post_rst_co", 64'(out_co), 64'd1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
